// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;
  localparam int DIV_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;
endpackage

// File: rtl/restoring_divider8_trial_subtractor.sv
// Ripple full-adder cell and the T - D trial subtractor built from it.
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module trial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   t_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o
);
  logic [WIDTH:0] c;

  assign c[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    fa_cell u_fa (
      .a_i(t_i[i]),
      .b_i(~d_i[i]),
      .c_i(c[i]),
      .s_o(diff_o[i]),
      .c_o(c[i+1])
    );
  end

  // Top cell adds the inverted zero-extension bit (1): carry is t | c.
  assign borrow_o = ~(t_i[WIDTH] | c[WIDTH]);
endmodule

// File: rtl/restoring_divider8.sv
// Unsigned restoring divider, one quotient bit per clock, Run-style handshake.
module restoring_divider8
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  assign t = {r_q, q_q[WIDTH-1]};

  trial_subtractor #(
    .WIDTH(WIDTH)
  ) u_sub (
    .t_i(t),
    .d_i(d_q),
    .diff_o(diff),
    .borrow_o(borrow)
  );

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          q_d   = Dividend;
          d_d   = Divisor;
          r_d   = '0;
          cnt_d = '0;
          if (Divisor == '0) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = Dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        // A restore only happens when T < D, so T's MSB is zero.
        r_d   = borrow ? t[WIDTH-1:0] : diff;
        q_d   = {q_q[WIDTH-2:0], ~borrow};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          quo_d   = q_d;
          rem_d   = r_d;
          dbz_d   = 1'b0;
        end
      end
      DONE: begin
        if (!Start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign Quotient  = quo_q;
  assign Remainder = rem_q;
  assign DivByZero = dbz_q;
  assign Busy      = (state_q == CALC);
  assign Done      = (state_q == DONE);
endmodule

// File: tb/tb_restoring_divider8.sv
// Directed-vector bench for restoring_divider8.
module tb_restoring_divider8;
  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       Start;
  logic [7:0] Dividend;
  logic [7:0] Divisor;
  logic [7:0] Quotient;
  logic [7:0] Remainder;
  logic       Busy;
  logic       Done;
  logic       DivByZero;

  int checks = 0;
  int errors = 0;

  restoring_divider8 dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .Start(Start),
    .Dividend(Dividend),
    .Divisor(Divisor),
    .Quotient(Quotient),
    .Remainder(Remainder),
    .Busy(Busy),
    .Done(Done),
    .DivByZero(DivByZero)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    @(negedge Clk);
    Dividend = a;
    Divisor  = b;
    Start    = 1'b1;
  endtask

  // Counts edges after E0 until Done, bounded.
  task automatic wait_done(input int n0, output int n, output bit both);
    n    = n0;
    both = 0;
    while (!Done && n < 40) begin
      @(posedge Clk);
      #1;
      n++;
      if (Busy && Done) both = 1;
    end
  endtask

  task automatic op(input string tag, input logic [7:0] a,
                    input logic [7:0] b, input logic [7:0] eq,
                    input logic [7:0] er, input logic edbz);
    int n;
    bit both;
    start_op(a, b);
    @(posedge Clk);
    #1;
    chk({tag, " busy_e0"}, Busy, !edbz);
    wait_done(0, n, both);
    chk({tag, " latency"}, n, edbz ? 0 : 8);
    chk({tag, " quot"}, Quotient, eq);
    chk({tag, " rem"}, Remainder, er);
    chk({tag, " dbz"}, DivByZero, edbz);
    chk({tag, " busy_done"}, both, 0);
  endtask

  task automatic end_op(input string tag);
    @(negedge Clk);
    Start = 1'b0;
    @(posedge Clk);
    #1;
    chk({tag, " idle"}, Done, 0);
  endtask

  initial begin
    int n;
    bit both;
    Reset_n  = 1'b0;
    Start    = 1'b0;
    Dividend = 8'd0;
    Divisor  = 8'd0;
    #12;
    chk("rst quot", Quotient, 0);
    chk("rst rem", Remainder, 0);
    chk("rst busy", Busy, 0);
    chk("rst done", Done, 0);
    chk("rst dbz", DivByZero, 0);
    @(negedge Clk);
    Reset_n = 1'b1;

    op("200/7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
    end_op("200/7");
    op("255/1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
    end_op("255/1");
    op("5/9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
    end_op("5/9");
    op("255/255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
    end_op("255/255");
    op("100/0", 8'd100, 8'd0, 8'hFF, 8'd100, 1'b1);
    end_op("100/0");
    op("10/3", 8'd10, 8'd3, 8'd3, 8'd1, 1'b0);
    end_op("10/3");

    // Start held across completion: one operation only.
    op("13/4", 8'd13, 8'd4, 8'd3, 8'd1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(posedge Clk);
      #1;
      chk("hold done", Done, 1);
      chk("hold busy", Busy, 0);
    end
    end_op("13/4");
    op("9/2", 8'd9, 8'd2, 8'd4, 8'd1, 1'b0);
    end_op("9/2");

    // Asynchronous reset mid-iteration.
    start_op(8'd200, 8'd7);
    @(posedge Clk);
    #1;
    repeat (4) begin
      @(posedge Clk);
      #1;
    end
    chk("pre-rst busy", Busy, 1);
    #2;
    Reset_n = 1'b0;
    Start   = 1'b0;
    #1;
    chk("arst quot", Quotient, 0);
    chk("arst rem", Remainder, 0);
    chk("arst busy", Busy, 0);
    chk("arst done", Done, 0);
    chk("arst dbz", DivByZero, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    chk("post-rst idle", Busy | Done, 0);
    op("50/6", 8'd50, 8'd6, 8'd8, 8'd2, 1'b0);
    end_op("50/6");

    // Operands and Start disturbed during CALC.
    start_op(8'd200, 8'd7);
    @(posedge Clk);
    #1;
    chk("mid busy_e0", Busy, 1);
    @(negedge Clk);
    Dividend = 8'd3;
    Divisor  = 8'd0;
    @(posedge Clk);
    #1;
    @(negedge Clk);
    Start = 1'b0;
    @(posedge Clk);
    #1;
    @(negedge Clk);
    Start = 1'b1;
    @(posedge Clk);
    #1;
    chk("mid hold quot", Quotient, 8);
    chk("mid hold rem", Remainder, 2);
    chk("mid busy", Busy, 1);
    wait_done(3, n, both);
    chk("mid latency", n, 8);
    chk("mid quot", Quotient, 28);
    chk("mid rem", Remainder, 4);
    chk("mid dbz", DivByZero, 0);
    chk("mid busy_done", both, 0);
    end_op("mid");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
